// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM states, pattern codes and RGB565 colour-bar values for the sensor emulator.
package cam_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
    localparam logic [1:0] PAT_RAMP = 2'd0;
    localparam logic [1:0] PAT_BARS = 2'd1;
    localparam logic [1:0] PAT_RED  = 2'd2;
    localparam logic [1:0] PAT_ROW  = 2'd3;
    // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
    localparam logic [7:0][15:0] BAR_RGB = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };
endpackage

// File: rtl/cam_pclk_gen.sv
// cam_pclk_gen: divides clk into the free-running Pclk and strobes fall_tick on the clk that drops Pclk.
module cam_pclk_gen #(
    parameter int PCLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pclk,
    output logic o_fall_tick
);
    localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_pclk;
    logic          w_wrap;

    assign w_wrap      = r_div_cnt == DIV_LAST;
    assign o_pclk      = r_pclk;
    assign o_fall_tick = w_wrap & r_pclk;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_pclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + DW'(1);
            if (w_wrap) r_pclk <= ~r_pclk;
        end
    end
endmodule

// File: rtl/camara_sensor_emu.sv
// camara_sensor_emu: OV7670-style sensor transmitter producing Vsyn/Href timing and RGB565 test patterns.
module camara_sensor_emu
    import cam_pkg::*;
#(
    parameter int PCLK_DIV    = 2,
    parameter int H_ACTIVE    = 160,
    parameter int H_BLANK     = 16,
    parameter int V_ACTIVE    = 120,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [1:0] i_pattern,
    output logic       o_pclk,
    output logic       o_vsyn,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_frame_done,
    output logic       o_busy
);
    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int L_ACT    = VSYNC_LINES + V_BACK;
    localparam int L_VF     = L_ACT + V_ACTIVE;
    localparam int L_TOT    = L_VF + V_FRONT;
    localparam int CW       = $clog2(LINE_LEN + 1);
    localparam int LW       = $clog2(L_TOT + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] HREF_END  = CW'(2 * H_ACTIVE);
    localparam logic [CW-1:0] BAR_W     = CW'(H_ACTIVE / 8);
    localparam logic [LW-1:0] LINE_LAST = LW'(L_TOT - 1);
    localparam logic [LW-1:0] LV_B      = LW'(VSYNC_LINES);
    localparam logic [LW-1:0] LV_A      = LW'(L_ACT);
    localparam logic [LW-1:0] LV_F      = LW'(L_VF);

    // Frame region of a line index; zero-length regions fall through naturally.
    function automatic state_t region(input logic [LW-1:0] l);
        return (l < LV_B) ? VSYNC : (l < LV_A) ? VBACK : (l < LV_F) ? ACTIVE : VFRONT;
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [LW-1:0] r_line;
    logic [1:0]    r_pat;
    logic          r_frame_done;
    logic          w_tick;
    logic          w_eol;
    logic          w_eof;
    logic          w_href;
    logic [LW-1:0] w_line_nx;
    logic [LW-1:0] w_row;
    logic [CW-1:0] w_x;
    logic [2:0]    w_bar;
    logic [15:0]   w_pix;
    logic [7:0]    w_pix_byte;

    cam_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_pclk     (o_pclk),
        .o_fall_tick(w_tick)
    );

    assign w_eol     = r_col == COL_LAST;
    assign w_eof     = w_eol && r_line == LINE_LAST;
    assign w_line_nx = r_line + LW'(w_eol);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_line       <= '0;
            r_pat        <= PAT_RAMP;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tick && r_state != IDLE && w_eof;
            if (w_tick) begin
                if (r_state == IDLE || w_eof) begin
                    r_col   <= '0;
                    r_line  <= '0;
                    r_state <= i_enable ? region('0) : IDLE;
                    if (i_enable) r_pat <= i_pattern;
                end else begin
                    r_col   <= w_eol ? '0 : r_col + CW'(1);
                    r_line  <= w_line_nx;
                    r_state <= region(w_line_nx);
                end
            end
        end
    end

    assign w_href     = r_state == ACTIVE && r_col < HREF_END;
    assign w_row      = r_line - LV_A;
    assign w_x        = r_col >> 1;
    assign w_bar      = 3'(w_x / BAR_W);
    assign w_pix      = (r_pat == PAT_RED) ? 16'hF800 : BAR_RGB[w_bar];
    assign w_pix_byte = r_col[0] ? w_pix[7:0] : w_pix[15:8];

    assign o_vsyn       = r_state == VSYNC;
    assign o_href       = w_href;
    assign o_busy       = r_state != IDLE;
    assign o_frame_done = r_frame_done;
    assign o_data       = !w_href ? 8'h00 :
                          (r_pat == PAT_RAMP) ? 8'(r_col) :
                          (r_pat == PAT_ROW)  ? 8'(w_row) : w_pix_byte;
endmodule

// File: tb/tb_camara_sensor_emu.sv
// tb_camara_sensor_emu: directed frame sequence with random pattern picks, checked against a frame-position model.
module tb_camara_sensor_emu;
    localparam int PD = 2, HA = 8, HB = 4, VA = 2, VS = 1, VB = 1, VF = 1;
    localparam int LL = 2 * HA + HB;
    localparam int NL = VS + VB + VA + VF;
    localparam int FP = LL * NL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] pat = 2'd0;
    logic       o_pclk, o_vsyn, o_href, o_frame_done, o_busy;
    logic [7:0] o_data;

    int checks = 0, fails = 0;
    int cyc = 0, vs_rise_cyc = 0, fd_cyc = 0, fd_cnt = 0;
    logic vs_prev = 1'b0;

    camara_sensor_emu #(
        .PCLK_DIV(PD), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pattern(pat),
        .o_pclk(o_pclk), .o_vsyn(o_vsyn), .o_href(o_href), .o_data(o_data),
        .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (o_vsyn && !vs_prev) vs_rise_cyc = cyc;
        vs_prev = o_vsyn;
        if (o_frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    function automatic logic [15:0] bar_rgb(input int i);
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Expected {busy, Vsyn, Href, data} at the k-th Pclk rise of a frame.
    function automatic logic [10:0] model(input int p, input int k);
        int ln = k / LL;
        int c = k % LL;
        logic vs = ln < VS;
        logic hr = ln >= VS + VB && ln < VS + VB + VA && c < 2 * HA;
        logic [15:0] px = (p == 2) ? 16'hF800 : bar_rgb((c / 2) / (HA / 8));
        logic [7:0] d = 8'h00;
        if (hr) d = (p == 0) ? 8'(c) : (p == 3) ? 8'(ln - VS - VB) : (c % 2 == 1) ? px[7:0] : px[15:8];
        return {1'b1, vs, hr, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_rise(output bit ok);
        logic p = o_pclk;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (!p && o_pclk) begin
                ok = 1'b1;
                return;
            end
            p = o_pclk;
        end
    endtask

    task automatic wait_vs_rise();
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_vsyn) begin
                seen = 1'b1;
                break;
            end
        end
        chk("vsync_start", 32'(seen), 32'd1);
    endtask

    task automatic run_frame(input int p, input int np, input bit en_after);
        bit ok;
        int start = 0, fd0 = 0;
        for (int k = 0; k < FP; k++) begin
            next_rise(ok);
            if (!ok) begin
                chk("pclk_timeout", 32'(ok), 32'd1);
                return;
            end
            if (k == 0) begin
                start = vs_rise_cyc;
                fd0 = fd_cnt;
            end
            chk($sformatf("frame_p%0d_k%0d", p, k), 32'({o_busy, o_vsyn, o_href, o_data}), 32'(model(p, k)));
            if (k == FP / 2) begin
                pat = 2'(np);
                en = en_after;
            end
        end
        repeat (4) @(negedge clk);
        chk("frame_done_count", 32'(fd_cnt - fd0), 32'd1);
        chk("frame_done_time", 32'(fd_cyc - start), 32'(2 * PD * FP));
        if (en_after) chk("next_vsync_no_gap", 32'(vs_rise_cyc - start), 32'(2 * PD * FP));
    endtask

    initial begin
        bit ok;
        int a, bad, r;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({o_pclk, o_vsyn, o_href, o_data, o_frame_done, o_busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_rise(ok);
        chk("pclk_running", 32'(ok), 32'd1);
        a = cyc;
        next_rise(ok);
        chk("pclk_period", 32'(cyc - a), 32'(2 * PD));
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({o_vsyn, o_href, o_data, o_busy, o_frame_done} != 0) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);
        chk("idle_no_frame_done", 32'(fd_cnt), 32'd0);

        r = $urandom_range(0, 3);
        pat = 2'd0;
        en = 1'b1;
        wait_vs_rise();
        run_frame(0, 1, 1'b1);
        run_frame(1, 3, 1'b1);
        run_frame(3, r, 1'b1);
        run_frame(r, 2, 1'b0);
        chk("busy_after_stop", 32'(o_busy), 32'd0);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (o_vsyn || o_busy || o_href) bad++;
        end
        chk("stays_idle", 32'(bad), 32'd0);

        pat = 2'($urandom_range(0, 3));
        en = 1'b1;
        wait_vs_rise();
        for (int k = 0; k < 45; k++) next_rise(ok);
        chk("href_before_reset", 32'(o_href), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 32'({o_pclk, o_vsyn, o_href, o_data, o_frame_done, o_busy}), 32'd0);
        repeat (5) @(negedge clk);
        pat = 2'd2;
        rst_n = 1'b1;
        wait_vs_rise();
        run_frame(2, 2, 1'b0);
        chk("busy_end", 32'(o_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/camara_sensor_emu.md
Name: camara_sensor_emu

Overview:
- Synthesizable emulator of the OV7670-style camera sensor: the transmit end of the Pclk/Vsyn/Href/data[7:0] interface that camara receives.
- Generates sensor timing and RGB565 test-pattern bytes from the system clock.
- Drives camara in simulation and on-board bring-up in place of the real sensor.

Parameters:
PCLK_DIV, 2, clk cycles per Pclk half-period (Pclk period = 2*PCLK_DIV clk); must be >=1
H_ACTIVE, 160, pixels per line (2 bytes/pixel); must be a multiple of 8
H_BLANK, 16, Pclk periods with Href low at the end of each active line
V_ACTIVE, 120, active lines per frame
VSYNC_LINES, 3, lines with Vsyn high
V_BACK, 2, blank lines after Vsyn, before the first active line
V_FRONT, 2, blank lines after the last active line

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  level: stream frames while high
pattern  in  2  test pattern select, sampled at frame start
Pclk  out  1  pixel clock, free-running after reset
Vsyn  out  1  vertical sync, active high
Href  out  1  line valid, active high
data  out  8  pixel byte
frame_done  out  1  one-clk pulse at the end of each frame
busy  out  1  high from frame start to frame end

Behaviour:
- Reset (reset=0, async): Pclk=0, Vsyn=0, Href=0, data=0, frame_done=0, busy=0, state IDLE, all counters 0.
- Pclk generation: div_cnt counts 0..PCLK_DIV-1. Pclk toggles when div_cnt wraps.
  - The toggle 1->0 asserts an internal fall_tick for one clk.
  - Pclk runs regardless of enable.
- All sensor outputs and counters update only on fall_tick. Receivers sample them stably on Pclk rise.
- Line length LINE_LEN = 2*H_ACTIVE + H_BLANK Pclk periods.
  - col counts 0..LINE_LEN-1, then wraps, and line increments.
- States:
  - IDLE: on fall_tick with enable=1, go to VSYNC; latch pattern; set busy=1; col=0, line=0.
  - VSYNC: Vsyn=1 for VSYNC_LINES lines, then go to VBACK.
  - VBACK: Vsyn=0 for V_BACK lines, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. Href=1 while col<2*H_ACTIVE; Href=0 during blanking. Then go to VFRONT.
  - VFRONT: V_FRONT lines. On the final fall_tick of the frame, pulse frame_done for one clk.
    - If enable=1, go to VSYNC and relatch pattern; busy stays 1.
    - Otherwise go to IDLE with busy=0.
- enable deasserted mid-frame: the current frame completes; no truncation.
- Pixel indices: x = col>>1; byte order is high byte first (col even = high byte, col odd = low byte). row = active line index 0..V_ACTIVE-1.
- data is 0 whenever Href=0.
- Patterns (2-bit code; each byte is 8 bits):
  - 0 = byte ramp: data = col[7:0].
  - 1 = colour bars: bar = x/(H_ACTIVE/8), pixel values in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2 = solid red: F800.
  - 3 = row ID: both bytes = row[7:0].
- Counter widths are derived with $clog2 of LINE_LEN and of the total line count; no overflow is permitted.
- Reset mid-frame: returns immediately to the reset values. After reset release, the next frame starts with a full VSYNC.

Decomposition:
- Package cam_pkg: state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT); pattern codes (PAT_RAMP, PAT_BARS, PAT_RED, PAT_ROW); the 8 RGB565 bar constants.
- Sub-module cam_pclk_gen: PCLK_DIV divider producing Pclk and the fall_tick strobe.
- The remaining timing FSM and pattern mux stay in camara_sensor_emu.

Test Plan (PCLK_DIV=2, H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; line = 20 Pclk, frame = 100 Pclk = 400 clk):
1. Reset held, then released with enable=0 -> Pclk period 4 clk; Vsyn/Href/data/busy stay 0 for 1000 clk.
2. enable=1, pattern=0 -> Vsyn high for exactly 20 Pclk. Two Href pulses of 16 Pclk each, separated by 4 low Pclk. Bytes on Pclk rise are 00..0F. frame_done pulses once, 400 clk after frame start.
3. pattern=1 -> bytes per line: FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
4. pattern=3 -> line 0: sixteen bytes of 00; line 1: sixteen bytes of 01.
5. enable held high -> next Vsyn rises on the Pclk fall after frame_done; no gap. A pattern change mid-frame takes effect only in the next frame.
6. enable dropped in the middle of ACTIVE -> frame completes with all 32 active bytes, then IDLE with busy=0. Separately, reset asserted mid-line -> all outputs 0 within the same clk.
